// File: rtl/hub75_scan_driver.sv
// HUB75 scan engine for a 32x32 panel: frame store fed by CPU pixel words, two-row scan-out.
// Define HUB75_DOUBLE_BUFFER_EN for a front/back buffer pair swapped only at frame end.
`timescale 1ns/1ps

module hub75_scan_driver #(
    parameter int unsigned ROW_HOLD = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mat_in,
    input  logic        wr_data,
    input  logic        init,
    output logic        ready,
    output logic        frame_start,
    output logic        clk_screen,
    output logic        R0,
    output logic        G0,
    output logic        B0,
    output logic        R1,
    output logic        G1,
    output logic        B1,
    output logic        blank,
    output logic        latch,
    output logic [4:0]  row
);

    localparam int unsigned SHIFT_LEN = 64;
    localparam int unsigned CNT_SPAN  = (ROW_HOLD > SHIFT_LEN) ? ROW_HOLD : SHIFT_LEN;
    localparam int unsigned CNT_W     = $clog2(CNT_SPAN);
    localparam int unsigned WPTR_W    = 7;
    localparam int unsigned PIX_W     = 24;
`ifdef HUB75_DOUBLE_BUFFER_EN
    localparam int unsigned ADDR_W    = 7;
`else
    localparam int unsigned ADDR_W    = 6;
`endif
    localparam int unsigned DEPTH     = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_SHIFT   = 2'd0,
        ST_LATCH   = 2'd1,
        ST_DISPLAY = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [3:0]          srow_q, srow_d;
    logic [WPTR_W-1:0]   wptr_q, wptr_d;
    logic                init_q;
    logic                init_rise;
    logic                wr_en;
    logic [WPTR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W-1:0]   rd_addr;
    logic [PIX_W-1:0]    mem_up [DEPTH];
    logic [PIX_W-1:0]    mem_lo [DEPTH];
    logic [PIX_W-1:0]    rd_up_q, rd_lo_q;
    logic [4:0]          pix_shift;
    logic [2:0]          pix_up, pix_lo;
    logic                clk_screen_q, blank_q, latch_q, frame_start_q;
    logic [3:0]          row_q;
    logic [2:0]          rgb0_q, rgb1_q;
    logic                unused_mat;

    assign init_rise  = init & ~init_q;
    assign wr_ptr     = init_rise ? '0 : wptr_q;
    assign unused_mat = ^mat_in[31:24];

`ifdef HUB75_DOUBLE_BUFFER_EN
    // A pending swap is the same condition as not ready: back buffer full, awaiting frame end.
    logic front_q, front_d;
    logic ready_q, ready_d;

    assign wr_en   = wr_data & ready_q;
    assign wr_addr = {~front_q, wr_ptr[5:0]};
    assign rd_addr = {front_d, srow_d, cnt_d[5:4]};
    assign ready   = ready_q;
`else
    assign wr_en   = wr_data;
    assign wr_addr = wr_ptr[5:0];
    assign rd_addr = {srow_d, cnt_d[5:4]};
    assign ready   = 1'b1;
`endif

    // Next-state: scan sequencing, buffer swap at frame end, write pointer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        srow_d  = srow_q;
`ifdef HUB75_DOUBLE_BUFFER_EN
        front_d = front_q;
        ready_d = ready_q;
`endif
        case (state_q)
            ST_SHIFT: begin
                if (cnt_q == CNT_W'(SHIFT_LEN - 1)) begin
                    state_d = ST_LATCH;
                    cnt_d   = '0;
                end
            end
            ST_LATCH: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DISPLAY;
                    cnt_d   = '0;
                end
            end
            ST_DISPLAY: begin
                if (cnt_q == CNT_W'(ROW_HOLD - 1)) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    srow_d  = srow_q + 4'd1;
`ifdef HUB75_DOUBLE_BUFFER_EN
                    if ((srow_q == 4'd15) && !ready_q) begin
                        front_d = ~front_q;
                        ready_d = 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = ST_SHIFT;
                cnt_d   = '0;
            end
        endcase

        wptr_d = wr_ptr;
        if (wr_en) begin
            wptr_d = wr_ptr + WPTR_W'(1);
`ifdef HUB75_DOUBLE_BUFFER_EN
            if (wr_ptr == WPTR_W'(127)) ready_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_SHIFT;
            cnt_q   <= '0;
            srow_q  <= '0;
            wptr_q  <= '0;
            init_q  <= 1'b0;
`ifdef HUB75_DOUBLE_BUFFER_EN
            front_q <= 1'b0;
            ready_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            srow_q  <= srow_d;
            wptr_q  <= wptr_d;
            init_q  <= init;
`ifdef HUB75_DOUBLE_BUFFER_EN
            front_q <= front_d;
            ready_q <= ready_d;
`endif
        end
    end

    // Pixel store; the read is issued for the column the scan reaches next cycle
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_ptr[6]) mem_lo[wr_addr] <= mat_in[PIX_W-1:0];
            else           mem_up[wr_addr] <= mat_in[PIX_W-1:0];
        end
        rd_up_q <= mem_up[rd_addr];
        rd_lo_q <= mem_lo[rd_addr];
    end

    assign pix_shift = 5'(cnt_q[3:1]) * 5'd3;
    assign pix_up    = 3'(rd_up_q >> pix_shift);
    assign pix_lo    = 3'(rd_lo_q >> pix_shift);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_screen_q  <= 1'b0;
            blank_q       <= 1'b1;
            latch_q       <= 1'b0;
            frame_start_q <= 1'b0;
            row_q         <= '0;
            rgb0_q        <= '0;
            rgb1_q        <= '0;
        end else begin
            clk_screen_q  <= (state_q == ST_SHIFT) && cnt_q[0];
            blank_q       <= (state_q != ST_DISPLAY);
            latch_q       <= (state_q == ST_LATCH) && (cnt_q == CNT_W'(1));
            frame_start_q <= (state_q == ST_SHIFT) && (cnt_q == '0) && (srow_q == 4'd0);
            if ((state_q == ST_LATCH) && (cnt_q == '0)) row_q <= srow_q;
            if (state_q == ST_SHIFT) begin
                rgb0_q <= pix_up;
                rgb1_q <= pix_lo;
            end
        end
    end

    assign clk_screen  = clk_screen_q;
    assign blank       = blank_q;
    assign latch       = latch_q;
    assign frame_start = frame_start_q;
    assign row         = {1'b0, row_q};
    assign R0 = rgb0_q[0];
    assign G0 = rgb0_q[1];
    assign B0 = rgb0_q[2];
    assign R1 = rgb1_q[0];
    assign G1 = rgb1_q[1];
    assign B1 = rgb1_q[2];

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Directed bench for hub75_scan_driver with ROW_HOLD=4 (row period 70, frame 1120 cycles).
`timescale 1ns/1ps

module tb_hub75_scan_driver;

    localparam int unsigned HOLD    = 4;
    localparam int unsigned ROW_P   = 66 + HOLD;
    localparam int unsigned FRAME_P = 16 * ROW_P;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mat_in;
    logic        wr_data;
    logic        init;
    logic        ready, frame_start, clk_screen;
    logic        R0, G0, B0, R1, G1, B1;
    logic        blank, latch;
    logic [4:0]  row;

    int          checks = 0;
    int          errors = 0;
    int          tb_wptr = 0;
    logic [2:0]  exp_img [32][32];
    logic [2:0]  geo_lo;

    hub75_scan_driver #(.ROW_HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .mat_in(mat_in), .wr_data(wr_data), .init(init),
        .ready(ready), .frame_start(frame_start), .clk_screen(clk_screen),
        .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
        .blank(blank), .latch(latch), .row(row)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_write(input logic [31:0] v);
        int y, x0;
        y  = tb_wptr / 4;
        x0 = 8 * (tb_wptr % 4);
        for (int i = 0; i < 8; i++) exp_img[y][x0 + i] = v[3*i +: 3];
        tb_wptr = (tb_wptr + 1) % 128;
    endtask

    task automatic write_word(input logic [31:0] v);
        @(negedge clk);
        wr_data = 1'b1;
        mat_in  = v;
        @(negedge clk);
        wr_data = 1'b0;
        mat_in  = '0;
    endtask

    // mode 0: every word = v; mode 1: only word 67 = 7
    task automatic load_frame(input int mode, input logic [31:0] v, input string name);
        logic [31:0] word;
        for (int w = 0; w < 128; w++) begin
            word = (mode == 1) ? ((w == 67) ? 32'h7 : 32'h0) : v;
            write_word(word);
            model_write(word);
`ifdef HUB75_DOUBLE_BUFFER_EN
            if (w == 126) begin
                checks++;
                if (ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_ready_after_127: ready=%b expected 1", name, ready);
                end
            end
            if (w == 127) begin
                checks++;
                if (ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_ready_after_128: ready=%b expected 0", name, ready);
                end
            end
`endif
        end
    endtask

    task automatic wait_swap(input string name);
`ifdef HUB75_DOUBLE_BUFFER_EN
        int n = 0;
        while (ready !== 1'b1 && n < 2 * FRAME_P) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_swap: ready=%b after %0d cycles, expected 1", name, ready, n);
        end
`else
        if (name.len() == 0) $display("empty name");
`endif
    endtask

    task automatic capture_frame(input string name);
        int waited, n, bad, fs, fc;
        logic prev;
        logic [2:0] gu, gl, eu, el, fgu, fgl, feu, fel;
        waited = 0; fs = 0; fc = 0;
        fgu = '0; fgl = '0; feu = '0; fel = '0;
        do begin
            @(negedge clk);
            waited++;
        end while (frame_start !== 1'b1 && waited < FRAME_P + 10);
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL %s_frame_start: none within %0d cycles", name, waited);
            return;
        end
`ifdef HUB75_DOUBLE_BUFFER_EN
        checks++;
        if (waited != 1) begin
            errors++;
            $display("FAIL %s_swap_latency: frame_start %0d cycles after ready, expected 1", name, waited);
        end
`endif
        prev = clk_screen;
        n = 0;
        bad = 0;
        for (int t = 0; t < FRAME_P && n < 512; t++) begin
            @(negedge clk);
            if (clk_screen === 1'b1 && prev !== 1'b1) begin
                gu = {B0, G0, R0};
                gl = {B1, G1, R1};
                eu = exp_img[n / 32][n % 32];
                el = exp_img[n / 32 + 16][n % 32];
                if (n == 24) geo_lo = gl;
                if (gu !== eu || gl !== el) begin
                    if (bad == 0) begin
                        fs = n / 32; fc = n % 32;
                        fgu = gu; fgl = gl; feu = eu; fel = el;
                    end
                    bad++;
                end
                n++;
            end
            prev = clk_screen;
        end
        checks++;
        if (n != 512 || bad != 0) begin
            errors++;
            $display("FAIL %s_pixels: %0d rises (exp 512), %0d bad; first row %0d col %0d got up %b lo %b exp up %b lo %b",
                     name, n, bad, fs, fc, fgu, fgl, feu, fel);
        end
    endtask

    task automatic test_reset();
        write_word(32'h00FFFFFF);
        write_word(32'h00FFFFFF);
        write_word(32'h00FFFFFF);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (blank !== 1'b1 || latch !== 1'b0 || row !== 5'd0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: blank=%b latch=%b row=%0d ready=%b expected 1 0 0 1", blank, latch, row, ready);
        end
        checks++;
        if (clk_screen !== 1'b0 || frame_start !== 1'b0 || {R0, G0, B0, R1, G1, B1} !== 6'b0) begin
            errors++;
            $display("FAIL reset_data: clk_screen=%b frame_start=%b rgb=%b expected 0 0 000000",
                     clk_screen, frame_start, {R0, G0, B0, R1, G1, B1});
        end
        @(negedge clk);
        rst = 1'b1;
        tb_wptr = 0;
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b1 || clk_screen !== 1'b0) begin
            errors++;
            $display("FAIL reset_cycle1: frame_start=%b clk_screen=%b expected 1 0", frame_start, clk_screen);
        end
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b0 || clk_screen !== 1'b1) begin
            errors++;
            $display("FAIL reset_cycle2: frame_start=%b clk_screen=%b expected 0 1", frame_start, clk_screen);
        end
    endtask

    task automatic test_full_frame();
        load_frame(0, 32'h00249249, "red");
`ifdef HUB75_DOUBLE_BUFFER_EN
        write_word(32'h00FFFFFF);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL overrun_ready: ready=%b expected 0", ready);
        end
`endif
        wait_swap("red");
        capture_frame("red");
    endtask

    task automatic test_row_sequencing();
        int waited = 0;
        int p, k;
        int bad_clk = 0, bad_blank = 0, bad_latch = 0, bad_row = 0, bad_fs = 0;
        logic [4:0] exp_row;
        while (frame_start !== 1'b1 && waited < FRAME_P + 10) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL rows_start: no frame_start within %0d cycles", waited);
            return;
        end
        for (int t = 0; t < FRAME_P; t++) begin
            p = t % ROW_P;
            k = t / ROW_P;
            exp_row = 5'((p >= 64) ? k : (k + 15) % 16);
            if (clk_screen !== ((p < 64) && (p % 2 == 1))) bad_clk++;
            if (blank !== (p < 66)) bad_blank++;
            if (latch !== (p == 65)) bad_latch++;
            if (row !== exp_row) bad_row++;
            if (frame_start !== (t == 0)) bad_fs++;
            @(negedge clk);
        end
        checks++;
        if (bad_clk != 0) begin errors++; $display("FAIL rows_clk_screen: %0d bad cycles, expected 0", bad_clk); end
        checks++;
        if (bad_blank != 0) begin errors++; $display("FAIL rows_blank: %0d bad cycles, expected 0", bad_blank); end
        checks++;
        if (bad_latch != 0) begin errors++; $display("FAIL rows_latch: %0d bad cycles, expected 0", bad_latch); end
        checks++;
        if (bad_row != 0) begin errors++; $display("FAIL rows_address: %0d bad cycles, expected 0", bad_row); end
        checks++;
        if (bad_fs != 0) begin errors++; $display("FAIL rows_frame_start: %0d bad cycles, expected 0", bad_fs); end
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL rows_frame_period: frame_start=%b at cycle %0d, expected 1", frame_start, FRAME_P);
        end
    endtask

    task automatic test_overrun_zero();
        load_frame(0, 32'h00000000, "zero");
        wait_swap("zero");
        capture_frame("zero");
    endtask

    task automatic test_init_rewind();
        for (int i = 0; i < 5; i++) begin
            write_word(32'h00FFFFFF);
            model_write(32'h00FFFFFF);
        end
        @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        tb_wptr = 0;
        load_frame(0, 32'h00492492, "green");
        wait_swap("green");
        capture_frame("green");
    endtask

    task automatic test_geometry();
        geo_lo = 3'bxxx;
        load_frame(1, 32'h0, "geo");
        wait_swap("geo");
        capture_frame("geo");
        checks++;
        if (geo_lo !== 3'b111) begin
            errors++;
            $display("FAIL geo_pixel: lower rgb at row 0 col 24 = %b expected 111", geo_lo);
        end
    endtask

    initial begin
        rst     = 1'b0;
        wr_data = 1'b0;
        init    = 1'b0;
        mat_in  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        test_reset();
        test_full_frame();
        test_row_sequencing();
        test_overrun_zero();
        test_init_rewind();
        test_geometry();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hub75_scan_driver.md
# hub75_scan_driver

Frame-buffered HUB75 scan engine for the 32x32 RGB LED panel. It sits directly downstream of the screen peripheral's register file, which sources `mat_in`, `wr_data` and `init`. It stores 1-bit-per-colour pixel words written by the CPU and continuously scans them out as two simultaneous half-panel rows (upper rows 0-15, lower rows 16-31). The panel shift clock, blank, latch and row address are generated here.

## Interface
- `ROW_HOLD`, 256, DISPLAY-state length in clk cycles; must be ≥1.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `mat_in`  in  32  pixel word. Bits [3i+2:3i] = {B,G,R} of pixel i, i=0..7; bits 31:24 are ignored.
- `wr_data`  in  1  one-cycle write strobe for `mat_in`.
- `init`  in  1  level. A rising edge rewinds the write pointer to 0.
- `ready`  out  1  high when writes are accepted.
- `frame_start`  out  1  one-cycle pulse on entry to row 0 SHIFT.
- `clk_screen`  out  1  panel shift clock.
- `R0`,`G0`,`B0`  out  1 each  upper-half pixel data.
- `R1`,`G1`,`B1`  out  1 each  lower-half pixel data.
- `blank`  out  1  panel output-enable, high = dark.
- `latch`  out  1  panel latch strobe.
- `row`  out  5  row-pair address; bit 4 is always 0.

## Operation
- **Write mapping**
  - 128 words per frame, word index w = 0..127 from write pointer `wptr`.
  - Panel y = w>>2. Pixel i of word w is at x = 8·(w&3)+i.
  - y<16 writes the upper array; y≥16 writes the lower array at y-16.
- **Storage**
  - Per buffer: two arrays, each 64 entries × 24 bits, addressed {y[3:0], seg[1:0]}. Upper and lower are read in parallel.
  - Memory is not reset.
- **Write acceptance**
  - When `wr_data` is high and `ready` is high: store the word into the back buffer at `wptr`, then `wptr`+1.
  - On the write at `wptr`=127: `wptr` wraps to 0, `swap_pending` is set, and `ready` goes 0.
  - Any `wr_data` while `ready`=0 is dropped; `wptr` is unchanged.
- **init**
  - A rising edge (`init` high now, low the previous cycle) sets `wptr`=0.
  - If the same cycle carries an accepted write, that word is stored at address 0 and `wptr` becomes 1.
  - `swap_pending` is unaffected.
- **Scan FSM**, starting at scan row s=0:
  - SHIFT, 64 cycles, column c=0..31:
    - cycle 2c: `R0..B1` = pixel (c, s) and (c, s+16) from the front buffer; `clk_screen`=0.
    - cycle 2c+1: data held; `clk_screen`=1.
    - `blank`=1 throughout.
  - LATCH, 2 cycles, `blank`=1:
    - cycle 1: `row`←s.
    - cycle 2: `latch`=1.
  - DISPLAY, `ROW_HOLD` cycles: `blank`=0, `latch`=0, `clk_screen`=0.
    - Exit: s←s+1 mod 16, then SHIFT.
    - If s was 15 (frame end) and `swap_pending`=1: toggle the front buffer, clear `swap_pending`, `ready`←1.
- **Reset mid-operation:** all state returns to reset values immediately. A partially loaded back buffer is abandoned and `wptr`=0.

## Timing
- **Reset values:** `clk_screen`=0, `R0..B1`=0, `blank`=1, `latch`=0, `row`=0, `ready`=1, `frame_start`=0, FSM in SHIFT with s=0, c=0, front buffer 0.
- **First activity after reset:**
  - First rising `clk_screen` occurs on cycle 2 after `rst` deasserts.
  - `frame_start` pulses on cycle 1.
- **Periods:**
  - Row period = 66+`ROW_HOLD` cycles.
  - Frame period = 16·(66+`ROW_HOLD`).
- **Output registration:** all outputs are registered. Pixel data is valid no later than the cycle `clk_screen` rises (memory read is prefetched one cycle).
- **Write latency:** `ready` falls the cycle after the 128th accepted write.
- **Swap timing:**
  - `ready` rises the cycle after DISPLAY of row 15 ends.
  - The new buffer's first pixels appear in the immediately following row-0 SHIFT.
- **No tearing:** a buffer swap never occurs mid-frame.

## Configuration
- `HUB75_DOUBLE_BUFFER_EN` defined: behaviour as above, with two buffers and swap at frame end.
- Undefined:
  - Single buffer; writes go straight to the displayed buffer, so tearing is possible.
  - `ready` is tied to 1 and `swap_pending` does not exist.
  - `wptr` wraps 127→0 silently.
  - Memory is halved.

## Test plan
- **Reset:** assert `rst`=0 mid-SHIFT → next edge shows `blank`=1, `latch`=0, `row`=0, `ready`=1; release → `frame_start` pulse one cycle later.
- **Full frame load:** write 128 words of 0x00249249 (all red), `ROW_HOLD`=4.
  - `ready`=0 after word 128.
  - At next frame: `R0`=`R1`=1, `G`/`B`=0 on all 32 `clk_screen` rises of all 16 rows.
- **Overrun:** with `ready`=0, write 0x00FFFFFF → dropped. After the swap, write 128 words of 0 → that frame displays all 0.
- **init rewind:** write 5 words, pulse `init`, write 128 words of 0x00492492 (green) → `ready` drops exactly after the 128th; display is all green.
- **Row sequencing:** observe `row` 0..15 and wrap. Per row: 32 `clk_screen` rises, `latch` high exactly one cycle after `row` update, `blank`=0 for exactly `ROW_HOLD` cycles; row period 70 cycles for `ROW_HOLD`=4.
- **Geometry:** write only word 67 = 0x00000007, others 0 → only the pixel at x=24, y=16 is lit; it shows as `R1`,`G1`,`B1`=1 at column 24 when `row`=0.
